// File: rtl/pipeline_mem_wb_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
// The MEM stage is the master; the memory model or controller is the slave.
interface pipeline_mem_wb_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/pipeline_mem_wb.sv
// MEM stage and MEM/WB pipeline register: word load/store over a req/ack bus,
// an upstream stall while memory is busy, and misalignment/timeout error reporting.
module pipeline_mem_wb #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [68:0]              EXMEM_data,
    input  logic [4:0]               EXMEM_control,
    pipeline_mem_wb_if.master        mem,
    output logic                     Stall,
    output logic [31:0]              EXMEM_Data,
    output logic [31:0]              MEMWB_Data,
    output logic [4:0]               MEMWB_AddrC,
    output logic                     MEMWB_RegWrite,
    output logic                     mem_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] LP_LIMIT = 8'(TIMEOUT - 32'd1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_wcnt;
    logic [31:0] r_memwb_data;
    logic [4:0]  r_memwb_addrc;
    logic        r_memwb_rw;
    logic        r_err;

    logic [31:0] w_alu;
    logic [31:0] w_store;
    logic [4:0]  w_addrc;
    logic        w_regwrite;
    logic        w_memwrite;
    logic        w_memread;
    logic [1:0]  w_memtoreg;
    logic        w_memop;
    logic        w_misalign;
    logic        w_req;
    logic        w_stall;
    logic        w_abort;
    logic        w_wcnt_clr;
    logic        w_wcnt_inc;
    logic        w_load_sel;
    logic        w_misalign_err;

    assign w_alu      = EXMEM_data[68:37];
    assign w_store    = EXMEM_data[36:5];
    assign w_addrc    = EXMEM_data[4:0];
    assign w_regwrite = EXMEM_control[4];
    assign w_memwrite = EXMEM_control[3];
    assign w_memread  = EXMEM_control[2];
    assign w_memtoreg = EXMEM_control[1:0];

    assign w_memop        = w_memread | w_memwrite;
    assign w_misalign     = w_memop & (w_alu[1:0] != 2'b00);
    assign w_misalign_err = w_misalign & (r_state == ST_IDLE);
    assign w_load_sel     = w_memread & (w_memtoreg == 2'b01);

    // Next-state and handshake decode; an ack always beats the timeout limit.
    always_comb begin
        w_next     = r_state;
        w_req      = 1'b0;
        w_stall    = 1'b0;
        w_abort    = 1'b0;
        w_wcnt_clr = 1'b0;
        w_wcnt_inc = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_memop && !w_misalign) begin
                    w_req = 1'b1;
                    if (mem.mem_ack) begin
                        w_next = ST_IDLE;
                    end else begin
                        w_stall    = 1'b1;
                        w_next     = ST_WAIT;
                        w_wcnt_clr = 1'b1;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                w_req = 1'b1;
                if (mem.mem_ack) begin
                    w_next = ST_IDLE;
                end else if (r_wcnt == LP_LIMIT) begin
                    w_abort = 1'b1;
                    w_next  = ST_IDLE;
                end else begin
                    w_stall    = 1'b1;
                    w_wcnt_inc = 1'b1;
                    w_next     = ST_WAIT;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State, wait counter, MEM/WB register and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_wcnt        <= 8'd0;
            r_memwb_data  <= 32'd0;
            r_memwb_addrc <= 5'd0;
            r_memwb_rw    <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_wcnt_clr) begin
                r_wcnt <= 8'd0;
            end else if (w_wcnt_inc) begin
                r_wcnt <= r_wcnt + 8'd1;
            end else begin
                r_wcnt <= r_wcnt;
            end
            // Holding MEM/WB during a stall keeps forwarding and the repeated RF write valid.
            if (!w_stall) begin
                r_memwb_addrc <= w_addrc;
                r_memwb_rw    <= w_regwrite & ~w_abort & ~w_misalign;
                r_memwb_data  <= w_load_sel ? mem.mem_rdata : w_alu;
            end else begin
                r_memwb_addrc <= r_memwb_addrc;
                r_memwb_rw    <= r_memwb_rw;
                r_memwb_data  <= r_memwb_data;
            end
            if (w_misalign_err || w_abort) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end
        end
    end

    assign mem.mem_req   = w_req & ~reset;
    assign mem.mem_we    = w_memwrite;
    assign mem.mem_addr  = w_alu;
    assign mem.mem_wdata = w_store;

    assign Stall          = w_stall & ~reset;
    assign EXMEM_Data     = w_alu;
    assign MEMWB_Data     = r_memwb_data;
    assign MEMWB_AddrC    = r_memwb_addrc;
    assign MEMWB_RegWrite = r_memwb_rw;
    assign mem_err        = r_err;

endmodule

// File: tb/tb_pipeline_mem_wb.sv
// Self-checking bench for pipeline_mem_wb: single-cycle vector table plus
// hand-written multi-cycle sequences, with a MEM/WB scoreboard queue.
module tb_pipeline_mem_wb;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        reset;
    logic [68:0] exm_data;
    logic [4:0]  exm_ctrl;
    logic        stall;
    logic [31:0] exmem_data_o;
    logic [31:0] memwb_data;
    logic [4:0]  memwb_addrc;
    logic        memwb_rw;
    logic        err;

    pipeline_mem_wb_if mem_if ();

    pipeline_mem_wb #(.TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .EXMEM_data     (exm_data),
        .EXMEM_control  (exm_ctrl),
        .mem            (mem_if),
        .Stall          (stall),
        .EXMEM_Data     (exmem_data_o),
        .MEMWB_Data     (memwb_data),
        .MEMWB_AddrC    (memwb_addrc),
        .MEMWB_RegWrite (memwb_rw),
        .mem_err        (err)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  addrc;
        logic [4:0]  ctrl;
        logic [31:0] rdata;
        logic        ack;
        logic [31:0] exp_data;
        logic [4:0]  exp_addrc;
        logic        exp_rw;
        logic        exp_req;
        logic        exp_we;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addrc;
        logic        rw;
    } wb_t;

    wb_t  sb_q[$];
    vec_t vecs[7];
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] addrc,
                         input logic [4:0] ctrl, input logic [31:0] rdata, input logic ack);
        exm_data         = {alu, wd, addrc};
        exm_ctrl         = ctrl;
        mem_if.mem_rdata = rdata;
        mem_if.mem_ack   = ack;
    endtask

    task automatic push(input logic [31:0] data, input logic [4:0] addrc, input logic rw);
        wb_t e;
        e.data  = data;
        e.addrc = addrc;
        e.rw    = rw;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input string name);
        wb_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            chk({name, ".data"},  memwb_data,  e.data);
            chk({name, ".addrc"}, {27'd0, memwb_addrc}, {27'd0, e.addrc});
            chk({name, ".rw"},    {31'd0, memwb_rw},    {31'd0, e.rw});
        end
    endtask

    initial begin
        int s_cnt;
        int r_cnt;
        bit done;

        vecs[0] = '{32'h0000_1234, 32'h0, 5'd5,  5'b10000, 32'h0,         1'b0, 32'h0000_1234, 5'd5,  1'b1, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0100, 32'h0, 5'd7,  5'b10101, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 5'd7,  1'b1, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_0300, 32'h1111_2222, 5'd3, 5'b01000, 32'h5555_5555, 1'b1, 32'h0000_0300, 5'd3, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{32'h0000_0104, 32'h0, 5'd4,  5'b10100, 32'h7777_7777, 1'b1, 32'h0000_0104, 5'd4,  1'b1, 1'b1, 1'b0};
        vecs[4] = '{32'h0000_0108, 32'h0, 5'd8,  5'b11101, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 5'd8,  1'b1, 1'b1, 1'b1};
        vecs[5] = '{32'hFFFF_FFFF, 32'h0, 5'd31, 5'b00000, 32'h0,         1'b0, 32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_ABCD, 32'h0, 5'd2,  5'b10001, 32'h9999_9999, 1'b1, 32'h0000_ABCD, 5'd2,  1'b1, 1'b0, 1'b0};

        reset = 1'b1;
        drive(32'h0, 32'h0, 5'd0, 5'b00000, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.data",  memwb_data, 32'h0);
        chk("rst.addrc", {27'd0, memwb_addrc}, 32'h0);
        chk("rst.rw",    {31'd0, memwb_rw}, 32'h0);
        chk("rst.err",   {31'd0, err}, 32'h0);
        reset = 1'b0;

        // Single-cycle vectors: no stall, MEM/WB updated on the next edge.
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].alu, vecs[i].wd, vecs[i].addrc, vecs[i].ctrl, vecs[i].rdata, vecs[i].ack);
            push(vecs[i].exp_data, vecs[i].exp_addrc, vecs[i].exp_rw);
            @(negedge clk);
            chk($sformatf("v%0d.stall", i), {31'd0, stall}, 32'h0);
            chk($sformatf("v%0d.req", i),   {31'd0, mem_if.mem_req}, {31'd0, vecs[i].exp_req});
            chk($sformatf("v%0d.we", i),    {31'd0, mem_if.mem_we},  {31'd0, vecs[i].exp_we});
            chk($sformatf("v%0d.addr", i),  mem_if.mem_addr, vecs[i].alu);
            chk($sformatf("v%0d.fwd", i),   exmem_data_o, vecs[i].alu);
            chk($sformatf("v%0d.err", i),   {31'd0, err}, 32'h0);
            @(posedge clk);
            #1;
            pop_check($sformatf("v%0d", i));
        end

        // Store acked after three wait cycles; bus stable, MEM/WB held.
        drive(32'h0000_0200, 32'hA5A5_A5A5, 5'd9, 5'b01000, 32'h0, 1'b0);
        push(32'h0000_0200, 5'd9, 1'b0);
        for (int k = 0; k < 4; k++) begin
            mem_if.mem_ack = (k == 3);
            @(negedge clk);
            chk($sformatf("st%0d.stall", k), {31'd0, stall}, {31'd0, (k < 3)});
            chk($sformatf("st%0d.req", k),   {31'd0, mem_if.mem_req}, 32'h1);
            chk($sformatf("st%0d.we", k),    {31'd0, mem_if.mem_we}, 32'h1);
            chk($sformatf("st%0d.addr", k),  mem_if.mem_addr, 32'h0000_0200);
            chk($sformatf("st%0d.wdata", k), mem_if.mem_wdata, 32'hA5A5_A5A5);
            chk($sformatf("st%0d.hold", k),  memwb_data, 32'h0000_ABCD);
            @(posedge clk);
            #1;
        end
        pop_check("st");

        // Ack arrives exactly at the timeout limit: ack wins, no error.
        drive(32'h0000_0600, 32'h0, 5'd13, 5'b10101, 32'h600D_DA7A, 1'b0);
        push(32'h600D_DA7A, 5'd13, 1'b1);
        for (int k = 0; k < 5; k++) begin
            mem_if.mem_ack = (k == 4);
            @(negedge clk);
            chk($sformatf("lim%0d.stall", k), {31'd0, stall}, {31'd0, (k < 4)});
            chk($sformatf("lim%0d.req", k),   {31'd0, mem_if.mem_req}, 32'h1);
            @(posedge clk);
            #1;
        end
        pop_check("lim");
        chk("lim.err", {31'd0, err}, 32'h0);

        // Misaligned load: no request, bubble, sticky error.
        drive(32'h0000_0102, 32'h0, 5'd14, 5'b10101, 32'h1234_5678, 1'b0);
        push(32'h1234_5678, 5'd14, 1'b0);
        @(negedge clk);
        chk("mis.stall", {31'd0, stall}, 32'h0);
        chk("mis.req",   {31'd0, mem_if.mem_req}, 32'h0);
        chk("mis.err0",  {31'd0, err}, 32'h0);
        @(posedge clk);
        #1;
        pop_check("mis");
        chk("mis.err1", {31'd0, err}, 32'h1);

        // Reset in the second WAIT cycle.
        drive(32'h0000_0500, 32'h0, 5'd15, 5'b10101, 32'h0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rw.req",   {31'd0, mem_if.mem_req}, 32'h0);
        chk("rw.stall", {31'd0, stall}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(32'h0, 32'h0, 5'd0, 5'b00000, 32'h0, 1'b0);
        @(negedge clk);
        chk("rw.data",  memwb_data, 32'h0);
        chk("rw.addrc", {27'd0, memwb_addrc}, 32'h0);
        chk("rw.rw",    {31'd0, memwb_rw}, 32'h0);
        chk("rw.err",   {31'd0, err}, 32'h0);
        chk("rw.req2",  {31'd0, mem_if.mem_req}, 32'h0);
        chk("rw.stl2",  {31'd0, stall}, 32'h0);
        @(posedge clk);
        #1;

        // Load with ack withheld: timeout abort.
        drive(32'h0000_0400, 32'h0, 5'd12, 5'b10101, 32'h0BAD_0BAD, 1'b0);
        push(32'h0BAD_0BAD, 5'd12, 1'b0);
        s_cnt = 0;
        r_cnt = 0;
        done  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_if.mem_req) r_cnt++;
            if (stall) begin
                s_cnt++;
                @(posedge clk);
                #1;
            end else begin
                done = 1'b1;
                break;
            end
        end
        chk("to.done",  {31'd0, done}, 32'h1);
        chk("to.stall", s_cnt, TO);
        chk("to.req",   r_cnt, TO + 1);
        @(posedge clk);
        #1;
        pop_check("to");
        chk("to.err", {31'd0, err}, 32'h1);

        drive(32'h0000_BEEF, 32'h0, 5'd6, 5'b10000, 32'h0, 1'b0);
        push(32'h0000_BEEF, 5'd6, 1'b1);
        @(negedge clk);
        chk("nx.stall", {31'd0, stall}, 32'h0);
        chk("nx.req",   {31'd0, mem_if.mem_req}, 32'h0);
        @(posedge clk);
        #1;
        pop_check("nx");
        chk("nx.err", {31'd0, err}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
